// File: rtl/uart_bcd.sv
// UART transmitter/receiver with switch-selected baud rate and a 3-digit decimal seven-segment readout.
// The TX payload or the last good RX byte is shown, depending on the data direction.
module uart_bcd #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int DISP_W   = 21
) (
  input  logic              src_clk,
  input  logic              rst_n,
  input  logic [9:0]        Switches,
  input  logic              DataIn,
  input  logic              SendItem,
  output logic              DataOut,
  output logic [DISP_W-1:0] Display_out
);

  localparam logic [15:0] DIV_9600   = 16'(CLK_FREQ / 9600);
  localparam logic [15:0] DIV_19200  = 16'(CLK_FREQ / 19200);
  localparam logic [15:0] DIV_57600  = 16'(CLK_FREQ / 57600);
  localparam logic [15:0] DIV_115200 = 16'(CLK_FREQ / 115200);

  // IDLE | line idle ; START | start bit ; DATA | 8 data bits LSB first ; STOP | stop bit
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic [9:0]  r_sw_s1, r_sw_s2;
  logic        r_rx_s1, r_rx_s2, r_rx_prev;
  logic        r_send_s1, r_send_s2, r_send_prev;
  logic [1:0]  r_baud_sel;
  logic        r_data_dir;
  logic [15:0] w_div;
  logic        w_send_pulse;

  tx_state_t   r_tx_state, w_tx_state;
  logic [15:0] r_tx_cnt, w_tx_cnt, r_tx_div, w_tx_div;
  logic [2:0]  r_tx_bit, w_tx_bit;
  logic [7:0]  r_tx_shift, w_tx_shift;
  logic        r_tx_out, w_tx_out;

  rx_state_t   r_rx_state, w_rx_state;
  logic [15:0] r_rx_cnt, w_rx_cnt, r_rx_div, w_rx_div;
  logic [2:0]  r_rx_bit, w_rx_bit;
  logic [7:0]  r_rx_shift, w_rx_shift, r_rx_byte, w_rx_byte;

  logic [7:0]  w_disp_val;
  logic [11:0] w_bcd;
  logic [7:0]  w_bin;

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_s1     <= '0;
      r_sw_s2     <= '0;
      r_rx_s1     <= 1'b1;
      r_rx_s2     <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_send_s1   <= 1'b0;
      r_send_s2   <= 1'b0;
      r_send_prev <= 1'b0;
      r_baud_sel  <= 2'b00;
      r_data_dir  <= 1'b0;
    end else begin
      r_sw_s1     <= Switches;
      r_sw_s2     <= r_sw_s1;
      r_rx_s1     <= DataIn;
      r_rx_s2     <= r_rx_s1;
      r_rx_prev   <= r_rx_s2;
      r_send_s1   <= SendItem;
      r_send_s2   <= r_send_s1;
      r_send_prev <= r_send_s2;
      if (!r_sw_s2[0]) r_baud_sel <= r_sw_s2[2:1];
      else             r_data_dir <= r_sw_s2[1];
    end
  end

  assign w_send_pulse = r_send_s2 & ~r_send_prev;

  always_comb begin
    case (r_baud_sel)
      2'b00:   w_div = DIV_9600;
      2'b01:   w_div = DIV_57600;
      2'b10:   w_div = DIV_115200;
      default: w_div = DIV_19200;
    endcase
  end

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_div   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_out   <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_div   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_byte  <= '0;
    end else begin
      r_tx_state <= w_tx_state;
      r_tx_cnt   <= w_tx_cnt;
      r_tx_div   <= w_tx_div;
      r_tx_bit   <= w_tx_bit;
      r_tx_shift <= w_tx_shift;
      r_tx_out   <= w_tx_out;
      r_rx_state <= w_rx_state;
      r_rx_cnt   <= w_rx_cnt;
      r_rx_div   <= w_rx_div;
      r_rx_bit   <= w_rx_bit;
      r_rx_shift <= w_rx_shift;
      r_rx_byte  <= w_rx_byte;
    end
  end

  // Divider is latched at frame start so a baud change only affects the next frame.
  always_comb begin
    w_tx_state = r_tx_state;
    w_tx_cnt   = r_tx_cnt;
    w_tx_div   = r_tx_div;
    w_tx_bit   = r_tx_bit;
    w_tx_shift = r_tx_shift;
    w_tx_out   = r_tx_out;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_out = 1'b1;
        if (w_send_pulse && r_sw_s2[0] && !r_data_dir) begin
          w_tx_state = TX_START;
          w_tx_div   = w_div;
          w_tx_cnt   = w_div - 16'd1;
          w_tx_shift = {1'b0, r_sw_s2[9:3]};
          w_tx_out   = 1'b0;
        end
      end
      TX_START: begin
        if (r_tx_cnt == 16'd0) begin
          w_tx_state = TX_DATA;
          w_tx_cnt   = r_tx_div - 16'd1;
          w_tx_bit   = 3'd0;
          w_tx_out   = r_tx_shift[0];
        end else w_tx_cnt = r_tx_cnt - 16'd1;
      end
      TX_DATA: begin
        if (r_tx_cnt == 16'd0) begin
          w_tx_cnt = r_tx_div - 16'd1;
          if (r_tx_bit == 3'd7) begin
            w_tx_state = TX_STOP;
            w_tx_out   = 1'b1;
          end else begin
            w_tx_bit   = r_tx_bit + 3'd1;
            w_tx_shift = r_tx_shift >> 1;
            w_tx_out   = r_tx_shift[1];
          end
        end else w_tx_cnt = r_tx_cnt - 16'd1;
      end
      TX_STOP: begin
        if (r_tx_cnt == 16'd0) w_tx_state = TX_IDLE;
        else                   w_tx_cnt   = r_tx_cnt - 16'd1;
      end
      default: w_tx_state = TX_IDLE;
    endcase
  end

  always_comb begin
    w_rx_state = r_rx_state;
    w_rx_cnt   = r_rx_cnt;
    w_rx_div   = r_rx_div;
    w_rx_bit   = r_rx_bit;
    w_rx_shift = r_rx_shift;
    w_rx_byte  = r_rx_byte;
    case (r_rx_state)
      RX_IDLE: begin
        if (r_rx_prev && !r_rx_s2) begin
          w_rx_state = RX_START;
          w_rx_div   = w_div;
          w_rx_cnt   = (w_div >> 1) - 16'd1;
        end
      end
      RX_START: begin
        if (r_rx_cnt == 16'd0) begin
          if (!r_rx_s2) begin
            w_rx_state = RX_DATA;
            w_rx_cnt   = r_rx_div - 16'd1;
            w_rx_bit   = 3'd0;
          end else w_rx_state = RX_IDLE;
        end else w_rx_cnt = r_rx_cnt - 16'd1;
      end
      RX_DATA: begin
        if (r_rx_cnt == 16'd0) begin
          w_rx_shift = {r_rx_s2, r_rx_shift[7:1]};
          w_rx_cnt   = r_rx_div - 16'd1;
          if (r_rx_bit == 3'd7) w_rx_state = RX_STOP;
          else                  w_rx_bit   = r_rx_bit + 3'd1;
        end else w_rx_cnt = r_rx_cnt - 16'd1;
      end
      RX_STOP: begin
        if (r_rx_cnt == 16'd0) begin
          if (r_rx_s2) w_rx_byte = r_rx_shift;
          w_rx_state = RX_IDLE;
        end else w_rx_cnt = r_rx_cnt - 16'd1;
      end
      default: w_rx_state = RX_IDLE;
    endcase
  end

  assign DataOut    = r_tx_out;
  assign w_disp_val = r_data_dir ? r_rx_byte : {1'b0, r_sw_s2[9:3]};

  always_comb begin
    w_bcd = '0;
    w_bin = w_disp_val;
    for (int i = 0; i < 8; i++) begin
      if (w_bcd[3:0]  > 4'd4) w_bcd[3:0]  = w_bcd[3:0]  + 4'd3;
      if (w_bcd[7:4]  > 4'd4) w_bcd[7:4]  = w_bcd[7:4]  + 4'd3;
      if (w_bcd[11:8] > 4'd4) w_bcd[11:8] = w_bcd[11:8] + 4'd3;
      w_bcd = {w_bcd[10:0], w_bin[7]};
      w_bin = {w_bin[6:0], 1'b0};
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign Display_out = {seg7(w_bcd[11:8]), seg7(w_bcd[7:4]), seg7(w_bcd[3:0])};

endmodule

// File: tb/tb_uart_bcd.sv
// Scoreboarded bench for uart_bcd: TX frames are checked by a line monitor against queued expectations,
// the display against a decimal reference model.
module tb_uart_bcd;
  localparam int CLK_FREQ = 100_000_000;

  logic        src_clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  Switches = '0;
  logic        DataIn = 1'b1;
  logic        SendItem = 1'b0;
  logic        DataOut;
  logic [20:0] Display_out;

  uart_bcd #(.CLK_FREQ(CLK_FREQ), .DISP_W(21)) dut (
    .src_clk(src_clk), .rst_n(rst_n), .Switches(Switches), .DataIn(DataIn),
    .SendItem(SendItem), .DataOut(DataOut), .Display_out(Display_out)
  );

  always #5 src_clk = ~src_clk;

  int n_vec = 0;
  int n_err = 0;

  int baud_m = 0;
  bit dir_m = 1'b0;
  int rx_m = 0;
  int pay_m = 0;

  typedef struct {
    logic [7:0] b;
    int         div;
    bit         abort;
  } tx_exp_t;
  tx_exp_t txq[$];
  bit mon_busy = 1'b0;
  int tx_frames = 0;

  logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  function automatic int div_of(input int sel);
    case (sel)
      0:       return CLK_FREQ / 9600;
      1:       return CLK_FREQ / 57600;
      2:       return CLK_FREQ / 115200;
      default: return CLK_FREQ / 19200;
    endcase
  endfunction

  function automatic logic [20:0] exp_disp(input int v);
    return {SEG[v / 100], SEG[(v / 10) % 10], SEG[v % 10]};
  endfunction

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_disp(input string name);
    check(name, Display_out, exp_disp(dir_m ? rx_m : pay_m));
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge src_clk);
  endtask

  task automatic set_sw(input int pay, input bit mode, input logic [1:0] sel);
    @(negedge src_clk);
    Switches = {7'(pay), sel, mode};
    if (!mode) baud_m = int'(sel);
    else       dir_m  = sel[0];
    pay_m = pay;
  endtask

  task automatic send_tx(input bit abort);
    tx_exp_t e;
    e.b = {1'b0, 7'(pay_m)};
    e.div = div_of(baud_m);
    e.abort = abort;
    txq.push_back(e);
    @(negedge src_clk);
    SendItem = 1'b1;
    wait_cyc(4);
    SendItem = 1'b0;
  endtask

  task automatic drive_rx(input logic [7:0] b, input int div, input bit stop_ok);
    @(negedge src_clk);
    DataIn = 1'b0;
    wait_cyc(div);
    for (int k = 0; k < 8; k++) begin
      DataIn = b[k];
      wait_cyc(div);
    end
    DataIn = stop_ok;
    wait_cyc(div);
    DataIn = 1'b1;
    wait_cyc(div);
    if (stop_ok) rx_m = int'(b);
  endtask

  task automatic wait_tx_done(input string name, input int budget);
    int c;
    c = 0;
    while ((txq.size() != 0 || mon_busy) && c < budget) begin
      @(negedge src_clk);
      c++;
    end
    n_vec++;
    if (c >= budget) begin
      n_err++;
      $display("FAIL %s: tx frame not finished after %0d cycles, %0d still queued", name, c, txq.size());
    end
  endtask

  // TX line monitor: samples each bit at its centre and measures the initial low run (baud check).
  initial begin
    tx_exp_t e;
    logic [9:0] got, want, mask;
    int nb, rise, total, tz, exp_run;
    bit ab, have;
    forever begin
      @(negedge src_clk);
      if (rst_n && DataOut === 1'b0) begin
        mon_busy = 1'b1;
        if (txq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL tx_unexpected: frame started, got 1 frame expected 0");
          e = '{8'h00, CLK_FREQ / 115200, 1'b0};
          have = 1'b0;
        end else begin
          e = txq.pop_front();
          have = 1'b1;
        end
        want = {1'b1, e.b, 1'b0};
        got = '0;
        nb = 0;
        rise = -1;
        ab = 1'b0;
        total = 9 * e.div + e.div / 2;
        for (int c = 0; c <= total; c++) begin
          if (c > 0) @(negedge src_clk);
          if (!rst_n) begin
            ab = 1'b1;
            break;
          end
          if (rise < 0 && DataOut === 1'b1) rise = c;
          if (c % e.div == e.div / 2) begin
            got[nb] = DataOut;
            nb++;
          end
        end
        if (have) begin
          check("tx_abort", 21'(ab), 21'(e.abort));
          mask = 10'((1 << nb) - 1);
          check("tx_bits", 21'(got & mask), 21'(want & mask));
          if (rise >= 0) begin
            tz = 0;
            while (tz < 8 && !e.b[tz]) tz++;
            exp_run = e.div * (1 + tz);
            n_vec++;
            if (rise - exp_run > 2 || exp_run - rise > 2) begin
              n_err++;
              $display("FAIL tx_low_run: got %0d cycles expected %0d", rise, exp_run);
            end
          end
        end
        if (!ab) tx_frames++;
        mon_busy = 1'b0;
        while (!rst_n) @(negedge src_clk);
      end
    end
  end

  initial begin
    int pay;
    logic [7:0] rb;
    #2 rst_n = 1'b0;
    wait_cyc(5);
    check("rst_disp", Display_out, exp_disp(0));
    check("rst_dout", 21'(DataOut), 21'(1));
    @(negedge src_clk);
    rst_n = 1'b1;
    wait_cyc(3);

    // config mode: baud follows switches, last value 01 (57600)
    set_sw(100, 1'b0, 2'b00);
    set_sw(100, 1'b0, 2'b01);
    set_sw(100, 1'b0, 2'b10);
    set_sw(100, 1'b0, 2'b11);
    set_sw(100, 1'b0, 2'b01);
    wait_cyc(5);
    check_disp("cfg_disp");

    // run mode: baud frozen, direction follows Switches[1]
    set_sw(100, 1'b1, 2'b00); wait_cyc(5); check_disp("dir_00");
    set_sw(100, 1'b1, 2'b01); wait_cyc(5); check_disp("dir_01");
    set_sw(100, 1'b1, 2'b10); wait_cyc(5); check_disp("dir_10");
    set_sw(100, 1'b1, 2'b11); wait_cyc(5); check_disp("dir_11");
    set_sw(100, 1'b1, 2'b01); wait_cyc(5); check_disp("dir_01b");

    // TX of 100 at 57600 while an 0xFF frame arrives on RX
    set_sw(100, 1'b1, 2'b00);
    wait_cyc(5);
    send_tx(1'b0);
    fork
      wait_tx_done("tx_100", 25000);
      drive_rx(8'hFF, div_of(1), 1'b1);
    join
    check_disp("tx100_disp");
    set_sw(100, 1'b1, 2'b01);
    wait_cyc(5);
    check_disp("rx_ff_disp");

    // switch to 115200, back to run with dir=1
    set_sw(100, 1'b0, 2'b10); wait_cyc(5); check_disp("cfg_hold_dir");
    set_sw(100, 1'b1, 2'b01); wait_cyc(5);

    rb = 8'($urandom);
    drive_rx(rb, div_of(2), 1'b0);
    wait_cyc(5);
    check_disp("rx_frame_err");

    @(negedge src_clk);
    DataIn = 1'b0;
    wait_cyc(100);
    DataIn = 1'b1;
    wait_cyc(1000);
    check_disp("rx_glitch");

    rb = 8'($urandom);
    drive_rx(rb, div_of(2), 1'b1);
    wait_cyc(5);
    check_disp("rx_rand");

    // held button plus a second press mid-frame: one frame only
    pay = int'($urandom_range(0, 127));
    set_sw(pay, 1'b1, 2'b00);
    wait_cyc(5);
    check_disp("tx_rand_disp");
    begin
      tx_exp_t e;
      e.b = {1'b0, 7'(pay_m)};
      e.div = div_of(baud_m);
      e.abort = 1'b0;
      txq.push_back(e);
    end
    @(negedge src_clk);
    SendItem = 1'b1;
    wait_cyc(3 * div_of(2));
    SendItem = 1'b0;
    wait_cyc(20);
    SendItem = 1'b1;
    wait_tx_done("tx_held", 12000);
    wait_cyc(300);
    SendItem = 1'b0;
    wait_cyc(300);
    check("tx_frame_count", 21'(tx_frames), 21'(2));

    // reset in the middle of a frame
    pay = int'($urandom_range(0, 127));
    set_sw(pay, 1'b1, 2'b00);
    wait_cyc(5);
    send_tx(1'b1);
    wait_cyc(2 * div_of(2));
    #3 rst_n = 1'b0;
    #1 check("rst_mid_dout", 21'(DataOut), 21'(1));
    baud_m = 0;
    dir_m = 1'b0;
    rx_m = 0;
    wait_cyc(3);
    check("rst_mid_disp", Display_out, exp_disp(0));
    @(negedge src_clk);
    rst_n = 1'b1;
    wait_cyc(5);
    check_disp("post_rst_disp");
    wait_tx_done("tx_abort1", 100);

    // after reset the baud must be 9600: start bit lasts 10416 cycles
    pay = int'($urandom_range(0, 63)) * 2 + 1;
    set_sw(pay, 1'b1, 2'b00);
    wait_cyc(5);
    send_tx(1'b1);
    wait_cyc(div_of(0) + 800);
    #3 rst_n = 1'b0;
    #1 check("rst2_dout", 21'(DataOut), 21'(1));
    @(negedge src_clk);
    rst_n = 1'b1;
    wait_tx_done("tx_abort2", 100);
    wait_cyc(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
